// File: rtl/general1_pkg.sv
// Shared general-purpose constant helpers.
package General1;

    // Smallest d with 10**d >= n: decimal digits needed to show 0..n-1.
    function automatic int clog10(input longint unsigned n);
        int             d;
        longint unsigned p;
        d = 0;
        p = 64'd1;
        for (int i = 0; i < 20; i++) begin
            if (p < n) begin
                p = p * 64'd10;
                d = d + 1;
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seg_pkg.sv
// Symbol, segment-code and FSM definitions for the 7-segment capture path.
package seg_pkg;

    typedef enum logic [3:0] {
        DIG0 = 4'd0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7, DIG8, DIG9,
        BLANK, MINUS, INVALID
    } symbol_t;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Active-high gfedcba codes.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Numeric weight of a symbol; blank and minus count as zero.
    function automatic logic [3:0] symbol_value(input symbol_t s);
        logic [3:0] v;
        if (s <= DIG9) begin
            v = s;
        end else begin
            v = 4'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decode of an active-low segment pattern into a display symbol.
module seg7_decoder
    import seg_pkg::*;
(
    input  logic [6:0] segments,
    output symbol_t    symbol
);

    logic [6:0] lit_s;

    // Invert to active-high and match against the known glyphs.
    always_comb begin
        lit_s  = ~segments;
        symbol = INVALID;
        case (lit_s)
            SEG_0:     symbol = DIG0;
            SEG_1:     symbol = DIG1;
            SEG_2:     symbol = DIG2;
            SEG_3:     symbol = DIG3;
            SEG_4:     symbol = DIG4;
            SEG_5:     symbol = DIG5;
            SEG_6:     symbol = DIG6;
            SEG_7:     symbol = DIG7;
            SEG_8:     symbol = DIG8;
            SEG_9:     symbol = DIG9;
            SEG_BLANK: symbol = BLANK;
            SEG_MINUS: symbol = MINUS;
            default:   symbol = INVALID;
        endcase
    end

endmodule

// File: rtl/segments2data.sv
// Samples a multiplexed 7-segment bus, captures settled digits and rebuilds
// the displayed number as a binary value with range checking.
module segments2data
    import seg_pkg::*;
#(
    parameter int    Size         = 5,
    parameter string Signed       = "No",
    parameter int    SettleCycles = 4,
    localparam int   ISize        = (Signed == "No") ? General1::clog10(longint'(1) << Size)
                                                     : General1::clog10(longint'(1) << (Size - 1)) + 1
)(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [ISize-1:0] Indicators,
    input  logic [7:0]       Segments,
    output logic [Size-1:0]  Data,
    output logic             Valid,
    output logic             Error
);

    localparam bit IS_SIGNED = (Signed == "Yes");
    localparam int ACC_W     = Size + 4;
    localparam int CNT_W     = $clog2(SettleCycles + 1);
    localparam int IDX_W     = (ISize > 1) ? $clog2(ISize) : 1;

    localparam logic [ACC_W-1:0] LIM_U    = ACC_W'((longint'(1) << Size) - longint'(1));
    localparam logic [ACC_W-1:0] LIM_POS  = ACC_W'((longint'(1) << (Size - 1)) - longint'(1));
    localparam logic [ACC_W-1:0] LIM_NEG  = ACC_W'(longint'(1) << (Size - 1));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SettleCycles);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(SettleCycles - 2);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(ISize - 1);

    logic [ISize-1:0] ind_r, ind_prev_r;
    logic [7:0]       seg_r, seg_prev_r;
    logic [CNT_W-1:0] cnt_r;
    symbol_t          slot_r [ISize];
    logic [ISize-1:0] mask_r;
    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [ACC_W-1:0] acc_r;
    logic [Size-1:0]  data_r;
    logic             valid_r, error_r;

    symbol_t          dec_sym_s;
    state_t           state_s;
    logic             stable_s, capture_s, bad_s, neg_s, range_err_s;
    logic [IDX_W-1:0] sel_s;
    logic [ISize-1:0] mask_s;
    logic [ACC_W-1:0] lim_s;
    logic [Size-1:0]  data_neg_s;

    seg7_decoder u_dec (
        .segments (seg_r[6:0]),
        .symbol   (dec_sym_s)
    );

    // Capture qualification, slot selection and end-of-frame checks.
    always_comb begin
        stable_s  = ({ind_r, seg_r} == {ind_prev_r, seg_prev_r});
        capture_s = stable_s && $onehot(~ind_r) && (cnt_r == CNT_FIRE) && (state_r == SCAN);
        mask_s    = capture_s ? (mask_r | ~ind_r) : mask_r;
        sel_s     = {IDX_W{1'b0}};
        for (int i = 0; i < ISize; i++) begin
            sel_s = ind_r[i] ? sel_s : IDX_W'(i);
        end
        bad_s = 1'b0;
        for (int i = 0; i < ISize; i++) begin
            bad_s = bad_s | (slot_r[i] == INVALID)
                          | ((slot_r[i] == MINUS) && ((i != ISize - 1) || !IS_SIGNED));
        end
        neg_s       = IS_SIGNED && (slot_r[ISize-1] == MINUS);
        lim_s       = !IS_SIGNED ? LIM_U : (neg_s ? LIM_NEG : LIM_POS);
        range_err_s = (acc_r > lim_s);
        data_neg_s  = {Size{1'b0}} - acc_r[Size-1:0];
    end

    // Next-state logic: scan until all slots captured, convert, then report.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SCAN:    state_s = (&mask_s) ? CONVERT : SCAN;
            CONVERT: state_s = (idx_r == {IDX_W{1'b0}}) ? DONE : CONVERT;
            DONE:    state_s = SCAN;
            default: state_s = SCAN;
        endcase
    end

    // Input sampling, settle counter, digit slots, Horner accumulator, outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ind_r      <= {ISize{1'b1}};
            ind_prev_r <= {ISize{1'b1}};
            seg_r      <= 8'hFF;
            seg_prev_r <= 8'hFF;
            cnt_r      <= {CNT_W{1'b0}};
            mask_r     <= {ISize{1'b0}};
            state_r    <= SCAN;
            idx_r      <= IDX_TOP;
            acc_r      <= {ACC_W{1'b0}};
            data_r     <= {Size{1'b0}};
            valid_r    <= 1'b0;
            error_r    <= 1'b0;
            for (int i = 0; i < ISize; i++) begin
                slot_r[i] <= BLANK;
            end
        end else begin
            ind_r      <= Indicators;
            seg_r      <= Segments;
            ind_prev_r <= ind_r;
            seg_prev_r <= seg_r;
            if (!stable_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            state_r <= state_s;
            valid_r <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                SCAN: begin
                    mask_r <= mask_s;
                    idx_r  <= IDX_TOP;
                    acc_r  <= {ACC_W{1'b0}};
                    if (capture_s) begin
                        slot_r[sel_s] <= dec_sym_s;
                    end
                end
                CONVERT: begin
                    acc_r <= acc_r * ACC_W'(10) + ACC_W'(symbol_value(slot_r[idx_r]));
                    idx_r <= idx_r - IDX_W'(1);
                end
                DONE: begin
                    mask_r <= {ISize{1'b0}};
                    if (bad_s || range_err_s) begin
                        error_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b1;
                        data_r  <= neg_s ? data_neg_s : acc_r[Size-1:0];
                    end
                end
                default: mask_r <= {ISize{1'b0}};
            endcase
        end
    end

    assign Data  = data_r;
    assign Valid = valid_r;
    assign Error = error_r;

endmodule

// File: tb/tb_segments2data.sv
// Table-driven scoreboard bench for segments2data in unsigned and signed builds.
module tb_segments2data;

    logic       clk = 1'b0;
    logic       rst_u, rst_s;
    logic [1:0] ind_u;
    logic [2:0] ind_s;
    logic [7:0] seg_u, seg_s;
    logic [4:0] data_u, data_s;
    logic       valid_u, valid_s, error_u, error_s;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         err;
        logic [4:0] data;
        int         at;
    } exp_t;

    typedef struct {
        bit          sgn;
        logic [23:0] segs;   // {slot2, slot1, slot0}
        bit          err;
        logic [4:0]  data;
    } vec_t;

    exp_t q_u[$];
    exp_t q_s[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    segments2data #(.Size(5), .Signed("No"), .SettleCycles(4)) dut_u (
        .Clock(clk), .Reset(rst_u), .Indicators(ind_u), .Segments(seg_u),
        .Data(data_u), .Valid(valid_u), .Error(error_u)
    );

    segments2data #(.Size(5), .Signed("Yes"), .SettleCycles(4)) dut_s (
        .Clock(clk), .Reset(rst_s), .Indicators(ind_s), .Segments(seg_s),
        .Data(data_s), .Valid(valid_s), .Error(error_s)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Unsigned-instance output monitor.
    always @(negedge clk) begin
        exp_t e;
        check("u_valid_error_exclusive", int'(valid_u & error_u), 0);
        if (valid_u || error_u) begin
            check("u_output_expected", int'(q_u.size() > 0), 1);
            if (q_u.size() > 0) begin
                e = q_u.pop_front();
                check("u_error_flag", int'(error_u), int'(e.err));
                check("u_data", int'(data_u), int'(e.data));
                check("u_latency", cyc, e.at);
            end
        end
    end

    // Signed-instance output monitor.
    always @(negedge clk) begin
        exp_t e;
        check("s_valid_error_exclusive", int'(valid_s & error_s), 0);
        if (valid_s || error_s) begin
            check("s_output_expected", int'(q_s.size() > 0), 1);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                check("s_error_flag", int'(error_s), int'(e.err));
                check("s_data", int'(data_s), int'(e.data));
                check("s_latency", cyc, e.at);
            end
        end
    end

    task automatic idle();
        ind_u = 2'b11;
        ind_s = 3'b111;
        seg_u = 8'hFF;
        seg_s = 8'hFF;
    endtask

    task automatic show(input bit sgn, input int k, input logic [7:0] code, input int hold);
        if (sgn) begin
            ind_s = ~(3'b001 << k);
            seg_s = code;
        end else begin
            ind_u = ~(2'b01 << k);
            seg_u = code;
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic push(input bit sgn, input bit err, input logic [4:0] data, input int n);
        exp_t e;
        e.err  = err;
        e.data = data;
        e.at   = cyc + n + 6;
        if (sgn) q_s.push_back(e);
        else     q_u.push_back(e);
    endtask

    task automatic drain(input bit sgn);
        int i;
        i = 0;
        while (((sgn ? q_s.size() : q_u.size()) > 0) && (i < 40)) begin
            @(negedge clk);
            i++;
        end
        check(sgn ? "s_frame_drained" : "u_frame_drained", sgn ? q_s.size() : q_u.size(), 0);
        if (sgn) q_s.delete();
        else     q_u.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_frame(input bit sgn, input logic [23:0] segs, input bit err,
                               input logic [4:0] data);
        int n;
        n = sgn ? 3 : 2;
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) push(sgn, err, data, n);
            show(sgn, k, segs[8*k +: 8], 6);
        end
        idle();
        drain(sgn);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 24'hFF_B0_F9, 1'b0, 5'd31};  // "31"
        vecs[1]  = '{1'b0, 24'hFF_B0_A4, 1'b1, 5'd31};  // "32" overflow
        vecs[2]  = '{1'b0, 24'hFF_FF_92, 1'b0, 5'd5};   // " 5"
        vecs[3]  = '{1'b0, 24'hFF_F9_FE, 1'b1, 5'd5};   // invalid glyph
        vecs[4]  = '{1'b0, 24'hFF_BF_F9, 1'b1, 5'd5};   // minus while unsigned
        vecs[5]  = '{1'b0, 24'hFF_C0_C0, 1'b0, 5'd0};   // "00"
        vecs[6]  = '{1'b0, 24'hFF_90_90, 1'b1, 5'd0};   // "99"
        vecs[7]  = '{1'b0, 24'hFF_B0_C0, 1'b0, 5'd30};  // "30"
        vecs[8]  = '{1'b1, 24'hBF_F9_82, 1'b0, 5'd16};  // "-16"
        vecs[9]  = '{1'b1, 24'hBF_F9_F8, 1'b1, 5'd16};  // "-17"
        vecs[10] = '{1'b1, 24'hFF_F9_92, 1'b0, 5'd15};  // " 15"
        vecs[11] = '{1'b1, 24'hFF_F9_82, 1'b1, 5'd15};  // " 16"
        vecs[12] = '{1'b1, 24'hFF_F9_BF, 1'b1, 5'd15};  // minus in units slot
        vecs[13] = '{1'b1, 24'hBF_FF_92, 1'b0, 5'd27};  // "- 5"
        vecs[14] = '{1'b1, 24'hBF_C0_90, 1'b0, 5'd23};  // "-09"
        vecs[15] = '{1'b1, 24'hFF_FF_80, 1'b0, 5'd8};   // "  8"

        rst_u = 1'b1;
        rst_s = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        check("reset_u_data", int'(data_u), 0);
        check("reset_u_valid", int'(valid_u), 0);
        check("reset_u_error", int'(error_u), 0);
        check("reset_s_data", int'(data_s), 0);
        check("reset_s_valid", int'(valid_s), 0);
        check("reset_s_error", int'(error_s), 0);
        rst_u = 1'b0;
        rst_s = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 16; v++) begin
            drive_frame(vecs[v].sgn, vecs[v].segs, vecs[v].err, vecs[v].data);
        end

        // Digit held one cycle short of settling must not be captured.
        show(1'b0, 0, 8'h99, 3);
        show(1'b0, 1, 8'hF9, 6);
        idle();
        repeat (15) @(negedge clk);
        check("glitch_data_held", int'(data_u), 30);
        push(1'b0, 1'b0, 5'd12, 2);
        show(1'b0, 0, 8'hA4, 6);
        idle();
        drain(1'b0);

        // Reset while converting discards the frame.
        show(1'b0, 0, 8'hF9, 6);
        show(1'b0, 1, 8'hA4, 5);
        rst_u = 1'b1;
        idle();
        @(negedge clk);
        rst_u = 1'b0;
        check("mid_reset_data", int'(data_u), 0);
        check("mid_reset_valid", int'(valid_u), 0);
        check("mid_reset_error", int'(error_u), 0);
        repeat (15) @(negedge clk);
        check("mid_reset_data_after", int'(data_u), 0);
        drive_frame(1'b0, 24'hFF_C0_F8, 1'b0, 5'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
